// File: rtl/time_display_scanner.sv
// time_display_scanner
//   Snapshots the three BCD time digits once per frame and time-multiplexes
//   them onto a single common-anode 7-segment bus.
//   Optional build macro: LEADING_ZERO_BLANK_EN (blank the minutes digit when 0).
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         synchronous, active-high
//   DisplayEnable 1 = scan, 0 = blank
//   S1, S2, S3    BCD digits: ones of seconds, tens of seconds, minutes
//   Seg           segments {g,f,e,d,c,b,a}, active-low (decoded from state/snapshot)
//   DigitSel      active-low one-hot digit enable, bit0 = S1 .. bit2 = S3
//   ColonN        colon drive, active-low
//   FrameTick     registered one-cycle pulse on each snapshot capture
module time_display_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       DisplayEnable,
  input  logic [3:0] S1,
  input  logic [3:0] S2,
  input  logic [3:0] S3,
  output logic [6:0] Seg,
  output logic [2:0] DigitSel,
  output logic       ColonN,
  output logic       FrameTick
);

  localparam logic [CNT_W-1:0] termCount = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       segBlank  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, DIG1, DIG2, DIG3} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] prescaler, prescalerNext;
  logic [3:0]       snap1, snap2, snap3;
  logic [3:0]       snap1Next, snap2Next, snap3Next;
  logic             frameTickNext;

  // BCD to active-low {g..a}; non-BCD codes show a dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // State, prescaler, snapshot and FrameTick registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      prescaler <= '0;
      snap1     <= 4'd0;
      snap2     <= 4'd0;
      snap3     <= 4'd0;
      FrameTick <= 1'b0;
    end else begin
      state     <= stateNext;
      prescaler <= prescalerNext;
      snap1     <= snap1Next;
      snap2     <= snap2Next;
      snap3     <= snap3Next;
      FrameTick <= frameTickNext;
    end
  end

  // Next-state, snapshot capture and display decode
  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    snap1Next     = snap1;
    snap2Next     = snap2;
    snap3Next     = snap3;
    frameTickNext = 1'b0;
    Seg           = segBlank;
    DigitSel      = 3'b111;
    ColonN        = 1'b1;

    case (state)
      IDLE: begin
        if (DisplayEnable) begin
          stateNext     = DIG1;
          prescalerNext = '0;
          snap1Next     = S1;
          snap2Next     = S2;
          snap3Next     = S3;
          frameTickNext = 1'b1;
        end
      end
      default: begin
        ColonN = 1'b0;
        if (state == DIG1) begin
          DigitSel = 3'b110;
          Seg      = decode(snap1);
        end else if (state == DIG2) begin
          DigitSel = 3'b101;
          Seg      = decode(snap2);
        end else begin
          DigitSel = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
          Seg      = (snap3 == 4'd0) ? segBlank : decode(snap3);
`else
          Seg      = decode(snap3);
`endif
        end

        // Disable wins over a terminal-count advance on the same edge
        if (!DisplayEnable) begin
          stateNext     = IDLE;
          prescalerNext = '0;
        end else if (prescaler == termCount) begin
          prescalerNext = '0;
          if (state == DIG1) begin
            stateNext = DIG2;
          end else if (state == DIG2) begin
            stateNext = DIG3;
          end else begin
            // Frame wrap: fresh snapshot for the next frame
            stateNext     = DIG1;
            snap1Next     = S1;
            snap2Next     = S2;
            snap3Next     = S3;
            frameTickNext = 1'b1;
          end
        end else begin
          prescalerNext = prescaler + CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_time_display_scanner.sv
// Bench for time_display_scanner: frame-position reference model checked
// every cycle, plus literal expectations along the directed scenario.
module tb_time_display_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 3 * DIV;

  logic       Clk;
  logic       Reset;
  logic       DisplayEnable;
  logic [3:0] S1, S2, S3;
  logic [6:0] Seg;
  logic [2:0] DigitSel;
  logic       ColonN;
  logic       FrameTick;

  int nTests = 0;
  int nFail  = 0;

  time_display_scanner #(.SCAN_DIV(DIV), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .DisplayEnable(DisplayEnable),
    .S1(S1), .S2(S2), .S3(S3),
    .Seg(Seg), .DigitSel(DigitSel), .ColonN(ColonN), .FrameTick(FrameTick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: whether scanning, position within the frame, snapshot
  bit       mValid  = 1'b0;
  bit       mActive = 1'b0;
  int       mPos    = 0;
  bit       mTick   = 1'b0;
  int       mSnap [3];

  function automatic logic [6:0] refSeg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic capture();
    mSnap[0] = int'(S1);
    mSnap[1] = int'(S2);
    mSnap[2] = int'(S3);
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      mValid  = 1'b1;
      mActive = 1'b0;
      mPos    = 0;
      mTick   = 1'b0;
      mSnap   = '{0, 0, 0};
    end else if (!mActive) begin
      mTick = 1'b0;
      if (DisplayEnable) begin
        mActive = 1'b1;
        mPos    = 0;
        mTick   = 1'b1;
        capture();
      end
    end else if (!DisplayEnable) begin
      mActive = 1'b0;
      mTick   = 1'b0;
    end else begin
      mPos  = (mPos + 1) % FRAME;
      mTick = (mPos == 0);
      if (mPos == 0) capture();
    end
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge Clk) begin
    logic [6:0] eSeg;
    logic [2:0] eSel;
    logic       eColon;
    int         d;
    if (mValid) begin
      eSeg   = 7'b1111111;
      eSel   = 3'b111;
      eColon = 1'b1;
      if (mActive) begin
        d       = mPos / DIV;
        eSel[d] = 1'b0;
        eColon  = 1'b0;
        eSeg    = refSeg(mSnap[d]);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 2 && mSnap[2] == 0) eSeg = 7'b1111111;
`endif
      end
      check("model_seg", Seg, eSeg);
      check("model_digitsel", 7'(DigitSel), 7'(eSel));
      check("model_colon", 7'(ColonN), 7'(eColon));
      check("model_frametick", 7'(FrameTick), 7'(mTick));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic checkOut(input string name, input logic [6:0] eSeg,
                          input logic [2:0] eSel, input logic eColon, input logic eTick);
    check({name, "_seg"}, Seg, eSeg);
    check({name, "_sel"}, 7'(DigitSel), 7'(eSel));
    check({name, "_colon"}, 7'(ColonN), 7'(eColon));
    check({name, "_tick"}, 7'(FrameTick), 7'(eTick));
  endtask

  initial begin
    logic [6:0] zeroSeg;
    Reset = 1'b1; DisplayEnable = 1'b0; S1 = 4'd0; S2 = 4'd0; S3 = 4'd0;
    cycles(2);
    checkOut("reset", 7'h7F, 3'b111, 1'b1, 1'b0);
    Reset = 1'b0;
    cycles(2);
    checkOut("idle", 7'h7F, 3'b111, 1'b1, 1'b0);

    // 1:05
    S3 = 4'd1; S2 = 4'd0; S1 = 4'd5; DisplayEnable = 1'b1;
    cycles(1);
    checkOut("dig1_first", 7'b0010010, 3'b110, 1'b0, 1'b1);
    cycles(3);
    checkOut("dig1_last", 7'b0010010, 3'b110, 1'b0, 1'b0);
    cycles(1);
    checkOut("dig2", 7'b1000000, 3'b101, 1'b0, 1'b0);
    S1 = 4'd7;
    cycles(4);
    checkOut("dig3", 7'b1111001, 3'b011, 1'b0, 1'b0);
    cycles(3);
    checkOut("dig3_still5_frame", 7'b1111001, 3'b011, 1'b0, 1'b0);
    cycles(1);
    checkOut("dig1_new7", 7'b1111000, 3'b110, 1'b0, 1'b1);

    // Invalid BCD on S2 shows a dash in the following frame
    S2 = 4'hC;
    cycles(4);
    checkOut("dig2_old", 7'b1000000, 3'b101, 1'b0, 1'b0);
    cycles(12);
    checkOut("dig2_dash", 7'b0111111, 3'b101, 1'b0, 1'b0);

    // Disable on DIG2 terminal cycle
    cycles(3);
    DisplayEnable = 1'b0;
    cycles(1);
    checkOut("disable", 7'h7F, 3'b111, 1'b1, 1'b0);
    cycles(2);
    checkOut("disable_hold", 7'h7F, 3'b111, 1'b1, 1'b0);

    // Re-enable with minutes = 0
    S3 = 4'd0; DisplayEnable = 1'b1;
    cycles(1);
    checkOut("reenable", 7'b1111000, 3'b110, 1'b0, 1'b1);
    cycles(3);
    checkOut("reenable_hold", 7'b1111000, 3'b110, 1'b0, 1'b0);
    cycles(5);
`ifdef LEADING_ZERO_BLANK_EN
    zeroSeg = 7'b1111111;
`else
    zeroSeg = 7'b1000000;
`endif
    checkOut("dig3_zero", zeroSeg, 3'b011, 1'b0, 1'b0);

    // Reset during DIG3 with enable still high
    Reset = 1'b1;
    cycles(1);
    checkOut("reset_mid", 7'h7F, 3'b111, 1'b1, 1'b0);
    cycles(1);
    checkOut("reset_held", 7'h7F, 3'b111, 1'b1, 1'b0);
    Reset = 1'b0;
    cycles(1);
    checkOut("after_reset", 7'b1111000, 3'b110, 1'b0, 1'b1);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) DisplayEnable = ~DisplayEnable;
      Reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) == 0) S1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) S2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) S3 = 4'($urandom_range(0, 15));
      cycles(1);
    end
    Reset = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/time_display_scanner.md
Name: time_display_scanner

Overview:
- Reader side of the counter's BCD time outputs (S3 = minutes, S2 = tens of seconds, S1 = ones of seconds).
- Takes a snapshot of the three digits once per frame and time-multiplexes them onto one common-anode 7-segment bus, with one-hot digit select and a colon drive.
- Sits between the time counter and the board display pins.

Parameters:
- SCAN_DIV, 4: clock cycles each digit is held; legal range is 2 to 2^CNT_W.
- CNT_W, 16: width of the prescaler counter.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- DisplayEnable  in  1  1 = scan the display, 0 = blank it.
- S1  in  4  ones-of-seconds BCD digit.
- S2  in  4  tens-of-seconds BCD digit.
- S3  in  4  minutes BCD digit.
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DigitSel  out  3  digit enables, active-low one-hot: bit0 = S1, bit1 = S2, bit2 = S3.
- ColonN  out  1  colon drive, active-low.
- FrameTick  out  1  one-cycle pulse on the edge that captures a new snapshot.

Behaviour:
- Reset and clock: one clock (Clk). Reset is synchronous, active-high, and has priority over every other input, including mid-frame.
- Reset values: state = IDLE, prescaler = 0, snapshot = {0,0,0}. Outputs: Seg = 7'b1111111, DigitSel = 3'b111, ColonN = 1, FrameTick = 0.
- States: IDLE, DIG1, DIG2, DIG3. State, prescaler and snapshot are registered.
  - Seg, DigitSel and ColonN are decoded combinationally from state and snapshot only; they never depend on the live S inputs.
  - FrameTick is registered.
- IDLE:
  - Outputs are blank (Seg = 7F, DigitSel = 111, ColonN = 1).
  - If DisplayEnable = 1 at an edge: state <= DIG1, snapshot <= {S3,S2,S1}, prescaler <= 0, FrameTick <= 1.
  - Latency: DigitSel = 110 is visible immediately after that edge.
- DIGn (n = 1..3):
  - DigitSel bit n-1 is 0, all others 1; Seg = decode(snapshot digit n); ColonN = 0.
  - Prescaler increments every cycle. On the edge where prescaler == SCAN_DIV-1, it resets to 0 and the state advances: DIG1 -> DIG2 -> DIG3 -> DIG1.
  - Each digit is therefore held exactly SCAN_DIV cycles, and a frame is 3*SCAN_DIV cycles.
- Frame wrap (DIG3 -> DIG1): snapshot <= {S3,S2,S1} and FrameTick <= 1 on the same edge. Input changes mid-frame never appear until the next frame.
- DisplayEnable = 0 in any DIGn: next edge goes to IDLE with prescaler <= 0; no snapshot is taken. This overrides terminal-count advance on the same edge.
- FrameTick is 0 on every edge that does not capture a snapshot.
- Decode, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10..15 (invalid BCD) = 0111111 (dash, g only).
- Re-enable after IDLE always restarts at DIG1 with a fresh snapshot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in DIG3 with snapshot S3 == 0, Seg = 1111111 (digit blank). DigitSel = 011 and ColonN = 0 are unchanged. Nonzero and invalid S3 decode normally.
- Undefined: S3 == 0 displays '0' (1000000).

Test Plan (SCAN_DIV = 4):
- Reset held 2 cycles, then DisplayEnable = 0 -> Seg = 7F, DigitSel = 111, ColonN = 1, FrameTick = 0 throughout.
- Release reset; S3:S2S1 = 1:05; assert enable:
  - DigitSel = 110 with Seg = 0010010 for 4 cycles, then 101 with Seg = 1000000 for 4 cycles, then 011 with Seg = 1111001 for 4 cycles.
  - FrameTick pulses on the enable edge and every 12 cycles after.
- Change S1 from 5 to 7 during DIG2 -> DIG1 still shows 5 until the next FrameTick; the next DIG1 shows 7 (1111000).
- Set S2 = 4'hC -> the DIG2 slot shows 0111111 in the following frame.
- Deassert enable during DIG2 on its terminal cycle -> IDLE next edge, all blank, no FrameTick. Reassert -> DIG1 starts with a full 4-cycle hold.
- Assert Reset during DIG3 -> reset values after that edge, regardless of DisplayEnable.
- S3 = 0 -> DIG3 Seg = 1000000, or 1111111 with LEADING_ZERO_BLANK_EN defined; DigitSel = 011 in both cases.
